// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and partial-product schedule for the sequential multiplier
//
// Purpose: FSM state encoding, step encoding and the per-step partial-product
// select table (which operand halves feed the shared multiplier and how far
// the product is shifted before accumulation).
// Ports: none (package).
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  localparam step_t STEP_FIRST = 2'd0;
  localparam step_t STEP_LAST  = 2'd3;

  // shift_halves counts the left shift in units of HALF bits (0, HALF or W).
  typedef struct packed {
    logic       a_hi;
    logic       b_hi;
    logic [1:0] shift_halves;
  } pp_sel_t;

  // Fixed order: LL, HL, LH, HH.
  function automatic pp_sel_t pp_sel(input step_t step);
    pp_sel_t s;
    case (step)
      2'd0:    s = '{a_hi: 1'b0, b_hi: 1'b0, shift_halves: 2'd0};
      2'd1:    s = '{a_hi: 1'b1, b_hi: 1'b0, shift_halves: 2'd1};
      2'd2:    s = '{a_hi: 1'b0, b_hi: 1'b1, shift_halves: 2'd1};
      default: s = '{a_hi: 1'b1, b_hi: 1'b1, shift_halves: 2'd2};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul16_unit.sv
// rtl/mul16_unit.sv - combinational HALFxHALF unsigned multiplier
//
// Purpose: the single multiplier resource shared across all four steps.
// Ports:
//   a  in  HALF    operand half, unsigned
//   b  in  HALF    operand half, unsigned
//   p  out 2*HALF  product a*b
module mul16_unit #(
  parameter int HALF = 16
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  logic [2*HALF-1:0] a_ext;
  logic [2*HALF-1:0] b_ext;

  assign a_ext = {{HALF{1'b0}}, a};
  assign b_ext = {{HALF{1'b0}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - sequential WxW->2W unsigned multiplier controller
//
// Purpose: time-shares one HALFxHALF multiplier over four cycles and
// accumulates shifted partial products; valid/ready handshakes on both sides.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand pair offered
//   in_ready   out  1   operands accepted this cycle when in_valid
//   a, b       in   W   unsigned operands
//   out_valid  out  1   y holds a finished product
//   out_ready  in   1   consumer takes y this cycle
//   y          out  2W  product
//   busy       out  1   high whenever not IDLE
module mul32_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int W     = 32,
  parameter int ROUTE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           busy
);

  localparam int HALF = W / 2;

  generate
    if (ROUTE != 0 || (W % 2) != 0) begin : g_bad_param
      $error("mul32_seq_ctrl: ROUTE must be 0 and W must be even");
    end
  endgenerate

  state_t         state_q, state_d;
  step_t          step_q, step_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] y_q, y_d;

  pp_sel_t        sel;
  logic [HALF-1:0] op_a, op_b;
  logic [W-1:0]   prod;
  logic [2*W-1:0] pp_ext, pp_shift, acc_sum;
  logic           accept;

  // Operand muxes: the only path into the shared multiplier.
  always_comb begin
    sel  = pp_sel(step_q);
    op_a = sel.a_hi ? a_q[W-1:HALF] : a_q[HALF-1:0];
    op_b = sel.b_hi ? b_q[W-1:HALF] : b_q[HALF-1:0];
  end

  mul16_unit #(.HALF(HALF)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_comb begin
    pp_ext = {{W{1'b0}}, prod};
    case (sel.shift_halves)
      2'd0:    pp_shift = pp_ext;
      2'd1:    pp_shift = pp_ext << HALF;
      default: pp_shift = pp_ext << W;
    endcase
    acc_sum = acc_q + pp_shift;
  end

  // in_ready is the only combinational input->output path (via out_ready).
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign y         = y_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MUL;
          step_d  = STEP_FIRST;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
        end
      end
      ST_MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == STEP_LAST) begin
          state_d = ST_DONE;
          // Separate result register keeps y stable while acc restarts.
          y_d     = acc_sum;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = ST_MUL;
            step_d  = STEP_FIRST;
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_FIRST;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

endmodule
